message_display: RTL and testbench

//  Consumes the 4-char ASCII game-state message (32 bit, char 0 in [31:24] = leftmost)
//  and drives a multiplexed 4-digit 7-segment display: one digit lit per slot, round-robin.

---
 rtl/message_display_pkg.sv | 68 ++++++
 rtl/ascii_seg7_decode.sv | 11 +
 rtl/message_display.sv | 150 +++++++++++++++
 tb/tb_message_display.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/message_display_pkg.sv
// Shared 7-segment glyph constants, ASCII-to-glyph lookup and flash FSM states
// for the message_display scan driver.
package message_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_G     = 7'b1101111;
    localparam logic [6:0] SEG_H     = 7'b1110100;
    localparam logic [6:0] SEG_I     = 7'b0000100;
    localparam logic [6:0] SEG_L     = 7'b0111000;
    localparam logic [6:0] SEG_O     = 7'b1011100;
    localparam logic [6:0] SEG_P     = 7'b1110011;
    localparam logic [6:0] SEG_U     = 7'b0011100;
    localparam logic [6:0] SEG_Y     = 7'b1101110;

    typedef enum logic [1:0] {
        ST_SHOW,
        ST_FLASH_OFF,
        ST_FLASH_ON
    } flash_state_e;

    // Active-high {g,f,e,d,c,b,a}; anything without a glyph is blank.
    function automatic logic [6:0] ascii_to_seg7(input logic [7:0] ch);
        logic [6:0] seg;
        case (ch)
            "0":      seg = SEG_0;
            "1":      seg = SEG_1;
            "2":      seg = SEG_2;
            "3":      seg = SEG_3;
            "4":      seg = SEG_4;
            "5":      seg = SEG_5;
            "6":      seg = SEG_6;
            "7":      seg = SEG_7;
            "8":      seg = SEG_8;
            "9":      seg = SEG_9;
            "-":      seg = SEG_MINUS;
            "a", "A": seg = SEG_A;
            "d":      seg = SEG_D;
            "e", "E": seg = SEG_E;
            "f", "F": seg = SEG_F;
            "g":      seg = SEG_G;
            "h":      seg = SEG_H;
            "i":      seg = SEG_I;
            "l", "L": seg = SEG_L;
            "o":      seg = SEG_O;
            "p", "P": seg = SEG_P;
            "u":      seg = SEG_U;
            "y":      seg = SEG_Y;
            default:  seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ascii_seg7_decode.sv
// Combinational ASCII character to active-high 7-segment glyph decoder.
module ascii_seg7_decode
    import message_display_pkg::*;
(
    input  logic [7:0] i_char,
    output logic [6:0] o_seg_c
);

    always_comb o_seg_c = ascii_to_seg7(i_char);

endmodule

// File: rtl/message_display.sv
// Multiplexed 4-digit 7-segment driver for a 4-char ASCII message, frame-latched.
// Optional MESSAGE_FLASH_EN: blink the display twice whenever the message changes.
module message_display
    import message_display_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_Mhz  = 12,
    parameter int unsigned DIGIT_PERIOD_us = 1000,
    parameter int unsigned BLANK_CYCLES    = 64,
    parameter int unsigned SEG_ACTIVE_LOW  = 1
`ifdef MESSAGE_FLASH_EN
    ,
    parameter int unsigned FLASH_FRAMES    = 60
`endif
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [31:0] i_Message,
    output logic [6:0]  o_Segments,
    output logic [3:0]  o_Digit_En
);

    localparam int unsigned SLOT_CYCLES = CLOCK_FREQ_Mhz * DIGIT_PERIOD_us;
    localparam int unsigned CW          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [6:0]  SEG_OFF     = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0]  EN_OFF      = (SEG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          first_q, first_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    en_q, en_d;
    logic [7:0]    cur_char;
    logic [6:0]    glyph;
    logic          slot_wrap, frame_start, dark, digit_on;

    // Slot/digit scan and frame-aligned message capture.
    always_comb begin
        slot_wrap   = (cnt_q == CW'(SLOT_CYCLES - 1));
        cnt_d       = slot_wrap ? '0 : cnt_q + CW'(1);
        idx_d       = slot_wrap ? idx_q + 2'd1 : idx_q;
        frame_start = first_q || (slot_wrap && (idx_q == 2'd3));
        shadow_d    = frame_start ? i_Message : shadow_q;
        first_d     = 1'b0;
    end

    always_comb begin
        cur_char = shadow_q[31:24];
        case (idx_q)
            2'd0:    cur_char = shadow_q[31:24];
            2'd1:    cur_char = shadow_q[23:16];
            2'd2:    cur_char = shadow_q[15:8];
            default: cur_char = shadow_q[7:0];
        endcase
    end

    ascii_seg7_decode u_decode (
        .i_char  (cur_char),
        .o_seg_c (glyph)
    );

`ifdef MESSAGE_FLASH_EN
    localparam int unsigned FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    flash_state_e  state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          second_q, second_d;

    // A change to a non-blank message restarts the OFF/ON/OFF/ON sequence.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        second_d = second_q;
        if (frame_start) begin
            if (i_Message != shadow_q) begin
                fcnt_d   = '0;
                second_d = 1'b0;
                state_d  = (i_Message == 32'h0) ? ST_SHOW : ST_FLASH_OFF;
            end else if (state_q != ST_SHOW) begin
                if (fcnt_q == FW'(FLASH_FRAMES - 1)) begin
                    fcnt_d = '0;
                    case (state_q)
                        ST_FLASH_OFF: state_d = ST_FLASH_ON;
                        ST_FLASH_ON: begin
                            if (second_q) begin
                                state_d = ST_SHOW;
                            end else begin
                                state_d  = ST_FLASH_OFF;
                                second_d = 1'b1;
                            end
                        end
                        default: state_d = ST_SHOW;
                    endcase
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= ST_SHOW;
            fcnt_q   <= '0;
            second_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            second_q <= second_d;
        end
    end

    assign dark = (state_q == ST_FLASH_OFF);
`else
    assign dark = 1'b0;
`endif

    // Pin drive: blanking window at slot start, then the indexed digit.
    always_comb begin
        digit_on = !dark && (cnt_q >= CW'(BLANK_CYCLES));
        seg_d    = digit_on ? glyph : SEG_BLANK;
        en_d     = digit_on ? (4'b1000 >> idx_q) : 4'b0000;
        if (SEG_ACTIVE_LOW != 0) begin
            seg_d = ~seg_d;
            en_d  = ~en_d;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 32'h0;
            first_q  <= 1'b1;
            seg_q    <= SEG_OFF;
            en_q     <= EN_OFF;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            first_q  <= first_d;
            seg_q    <= seg_d;
            en_q     <= en_d;
        end
    end

    assign o_Segments = seg_q;
    assign o_Digit_En = en_q;

endmodule

// File: tb/tb_message_display.sv
// Scoreboard bench for message_display: frame-level reference model feeds an expectation queue.
module tb_message_display;

    localparam int unsigned SLOT  = 16;
    localparam int unsigned BLANK = 2;
    localparam int FF    = 2;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] msg = 32'h0;
    logic [6:0]  seg;
    logic [3:0]  en;

    message_display #(
        .CLOCK_FREQ_Mhz  (1),
        .DIGIT_PERIOD_us (16),
        .BLANK_CYCLES    (2),
        .SEG_ACTIVE_LOW  (1)
`ifdef MESSAGE_FLASH_EN
        ,
        .FLASH_FRAMES    (FF)
`endif
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Message  (msg),
        .o_Segments (seg),
        .o_Digit_En (en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] en;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    logic [31:0] frame_msg = 32'h0;
    int          flash_pos = -1;

    function automatic logic [6:0] glyph(input logic [7:0] c);
        case (c)
            "0": return 7'b0111111;  "1": return 7'b0000110;
            "2": return 7'b1011011;  "3": return 7'b1001111;
            "4": return 7'b1100110;  "5": return 7'b1101101;
            "6": return 7'b1111101;  "7": return 7'b0000111;
            "8": return 7'b1111111;  "9": return 7'b1101111;
            "-": return 7'b1000000;
            "a", "A": return 7'b1110111;
            "d": return 7'b1011110;
            "e", "E": return 7'b1111001;
            "f", "F": return 7'b1110001;
            "g": return 7'b1101111;  "h": return 7'b1110100;
            "i": return 7'b0000100;
            "l", "L": return 7'b0111000;
            "o": return 7'b1011100;
            "p", "P": return 7'b1110011;
            "u": return 7'b0011100;  "y": return 7'b1101110;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [31:0] rand_msg();
        string       pool = "0123456789-aAdeEfFghilLopPuy ~ZGq";
        logic [31:0] r;
        if ($urandom_range(0, 7) == 0) return 32'h0;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 4) == 0) r[8*i +: 8] = 8'($urandom);
            else r[8*i +: 8] = pool[$urandom_range(0, pool.len() - 1)];
        end
        return r;
    endfunction

    // One clock: drive input, predict the pins after the next edge, then advance frame state.
    task automatic step(input logic [31:0] m);
        int   p, offs, d;
        bit   lit;
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        msg = m;
        n++;
        p    = n - 1;
        offs = p % SLOT;
        d    = (p / SLOT) % 4;
        lit  = (offs >= BLANK) && !(flash_pos >= 0 && ((flash_pos / FF) % 2 == 0));
        e.seg = lit ? glyph(frame_msg[8*(3-d) +: 8]) : 7'h00;
        e.en  = 4'h0;
        if (lit) e.en[3-d] = 1'b1;
        e.seg = ~e.seg;
        e.en  = ~e.en;
        exp_q.push_back(e);
        if (n == 1 || n % FRAME == 0) begin
`ifdef MESSAGE_FLASH_EN
            if (m != frame_msg) flash_pos = (m != 32'h0) ? 0 : -1;
            else if (flash_pos >= 0) begin
                flash_pos++;
                if (flash_pos == 4 * FF) flash_pos = -1;
            end
`endif
            frame_msg = m;
        end
    endtask

    task automatic run_to_frame(input logic [31:0] m);
        do step(m); while (n % FRAME != 0);
    endtask

    // Monitor: pins are valid every cycle, checked just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            checks++;
            if (seg !== 7'h7F || en !== 4'hF) begin
                errors++;
                $display("FAIL reset_state seg=%b en=%b required seg=1111111 en=1111", seg, en);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (seg !== e.seg || en !== e.en) begin
                errors++;
                $display("FAIL pins n=%0d seg=%b en=%b required seg=%b en=%b", n, seg, en, e.seg, e.en);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);

        repeat (2 * FRAME) step("le 3");

        run_to_frame("ladd");
        repeat (2 * SLOT + 4) step("ladd");
        repeat (2 * FRAME) step("fail");

        run_to_frame({8'h00, 8'h7E, "8", 8'h7E});
        repeat (FRAME) step({8'h00, 8'h7E, "8", 8'h7E});
        run_to_frame(32'h0);
        repeat (FRAME) step(32'h0);

        run_to_frame("le 3");
        repeat (2 * SLOT + 5) step("le 3");
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (seg !== 7'h7F || en !== 4'hF) begin
            errors++;
            $display("FAIL async_reset seg=%b en=%b required seg=1111111 en=1111", seg, en);
        end
        repeat (3) @(negedge clk);
        n = 0;
        frame_msg = 32'h0;
        flash_pos = -1;
        repeat (FRAME + SLOT) step("le 3");

        run_to_frame("le 3");
        repeat (FRAME) step("yeah");
        repeat (FRAME) step("lead");
        repeat (9 * FRAME) step("lead");
        repeat (3 * FRAME) step(32'h0);

        begin
            logic [31:0] cur;
            cur = rand_msg();
            repeat (3000) begin
                if ($urandom_range(0, 39) == 0) cur = rand_msg();
                step(cur);
            end
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
